mdu_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the main ALU in the execute stage. The control unit flags an M-extension instruction (R-type with funct7 bit 0 set) and raises `start` together with funct3. The sequencer then holds the pipeline via `stall` while a shift-add or restoring-divide datapath iterates. It releases the pipeline in the cycle where `result` is valid.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_sequencer.sv | 99 +++++++++
 tb/tb_mdu_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the RV32M multiply/divide sequencer.
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;
  localparam logic [6:0]  FUNCT7_MULDIV    = 7'b0000001;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
endpackage

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative shift-add multiplier / restoring divider with a pipeline-stall FSM.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] OVF = DIV_OVF_DIVIDEND[XLEN-1:0];

  mdu_state_e        state_q;
  mdu_op_e           op_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [XLEN-1:0]   opnd_q, result_q, mag_a, mag_b, spec_res, div_val, fix_d;
  logic [XLEN:0]     mul_sum, div_t, div_diff;
  logic              neg_q, neg_d, sa, sb, is_div, div0, ovf, div_q;
  mdu_op_e           op_i;

  assign op_i     = mdu_op_e'(funct3);
  assign is_div   = funct3[2];
  assign sa       = (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && srcA[XLEN-1];
  assign sb       = (op_i inside {OP_MULH, OP_DIV, OP_REM}) && srcB[XLEN-1];
  assign mag_a    = sa ? -srcA : srcA;
  assign mag_b    = sb ? -srcB : srcB;
  assign neg_d    = (op_i inside {OP_REM, OP_REMU}) ? sa : sa ^ sb;
  assign div0     = is_div && srcB == '0;
  assign ovf      = (op_i inside {OP_DIV, OP_REM}) && srcA == OVF && &srcB;
  assign spec_res = div0 ? (funct3[1] ? srcA : '1) : (funct3[1] ? '0 : OVF);

  // Multiply: accumulator is {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: accumulator is {partial remainder, dividend shifting into quotient}.
  assign div_t    = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_t - {1'b0, opnd_q};
  assign div_q    = !div_diff[XLEN];
  assign acc_d    = (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})
                  ? {div_q ? div_diff[XLEN-1:0] : div_t[XLEN-1:0], acc_q[XLEN-2:0], div_q}
                  : {mul_sum, acc_q[XLEN-1:1]};

  assign prod     = neg_q ? -acc_q : acc_q;
  assign div_val  = (op_q inside {OP_REM, OP_REMU}) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign fix_d    = (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? (neg_q ? -div_val : div_val)
                  : (op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (kill) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q   <= op_i;
          neg_q  <= neg_d;
          cnt_q  <= CW'(XLEN);
          acc_q  <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
          opnd_q <= is_div ? mag_b : mag_a;
          if (div0 || ovf) begin
            result_q <= spec_res;
            state_q  <= DONE;
          end else begin
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          result_q <= fix_d;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall  = (state_q == IDLE && start && !kill) || state_q == CALC || state_q == FIX;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench comparing the sequencer against an arithmetic RV32M model.
module tb_mdu_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] srcA = '0, srcB = '0;
  logic        stall, done;
  logic [31:0] result;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] x, y, p;
    int sa_i, sb_i;
    logic ovf;
    x = (f == 3'd1 || f == 3'd2) ? {{34{a[31]}}, a} : {34'd0, a};
    y = (f == 3'd1) ? {{34{b[31]}}, b} : {34'd0, b};
    p = x * y;
    sa_i = a;
    sb_i = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa_i / sb_i);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'(sa_i % sb_i);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h with no operation pending", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int lat, stalls, exp_lat;
    exp_lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
    @(negedge clk);
    start = 1'b1; funct3 = f; srcA = a; srcB = b;
    exp_q.push_back(model(f, a, b));
    #1 check("stall_t0", {31'd0, stall}, 32'd1);
    stalls = 1;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 1;
    while (!done && lat < 60) begin
      if (stall) stalls++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", lat, exp_lat);
    check("stall_cycles", stalls, exp_lat);
    check("stall_at_done", {31'd0, stall}, 32'd0);
    if (hold) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("no_relaunch_stall", {31'd0, stall}, 32'd0);
      check("no_relaunch_done", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Kill at T10 of a DIV, then a fresh op launched at T12.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; srcA = 32'hFFFF_FF9C; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill_stall", {31'd0, stall}, 32'd0);
    check("kill_done", {31'd0, done}, 32'd0);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd3, 1'b0);

    // Reset at T5 of a MUL.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; srcA = 32'd12345; srcB = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
